// File: rtl/schwap_mem_pkg.sv
// Shared types and defaults for the Schwap memory-side blocks.
package schwap_mem_pkg;

  localparam int unsigned DW_DEF = 16;
  localparam int unsigned AW_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_ACCESS = 3'd2,
    ST_RESP   = 3'd3,
    ST_DONE   = 3'd4,
    ST_HOLD   = 3'd5
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter with a zero flag; saturates at zero.
module mem_wait_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the Schwap multicycle core: one RAM access per strobe.
// Optional MEM_RANGE_CHECK_EN adds mem_err and suppresses accesses at addr >= DEPTH.
module mem_responder
  import schwap_mem_pkg::*;
#(
  parameter int unsigned DW          = DW_DEF,
  parameter int unsigned AW          = AW_DEF,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          mem_ready,
  output logic          busy,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
`ifdef MEM_RANGE_CHECK_EN
  ,
  output logic          mem_err
`endif
);

  if (WAIT_CYCLES > 15 || DEPTH == 0) begin : g_bad_cfg
    $error("mem_responder: WAIT_CYCLES must be 0..15 and DEPTH nonzero");
  end

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_e state, state_nxt;
  op_e    op;
  logic   strobe;
  logic   capture;
  logic   wait_zero;
  logic   skip;

  assign strobe  = mem_read | mem_write;
  assign capture = (state == ST_IDLE) && strobe;

  mem_wait_counter #(.W(4)) u_wait (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (capture),
    .load_val (WAIT_LOAD),
    .dec      (state == ST_WAIT),
    .zero     (wait_zero)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (strobe) state_nxt = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
      ST_WAIT:   if (wait_zero) state_nxt = ST_ACCESS;
      ST_ACCESS: state_nxt = (op == OP_WRITE) ? ST_DONE : ST_RESP;
      ST_RESP:   state_nxt = ST_DONE;
      ST_DONE:   state_nxt = strobe ? ST_HOLD : ST_IDLE;
      ST_HOLD:   if (!strobe) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      op        <= OP_READ;
      ram_addr  <= '0;
      ram_wdata <= '0;
      rdata     <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        ram_addr  <= addr;
        ram_wdata <= wdata;
        op        <= mem_write ? OP_WRITE : OP_READ;
      end
      if (state == ST_RESP) begin
        rdata <= skip ? '0 : ram_rdata;
      end
    end
  end

`ifdef MEM_RANGE_CHECK_EN
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  // Out-of-range requests still walk the normal state sequence so timing is unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skip <= 1'b0;
    end else if (capture) begin
      skip <= ({1'b0, addr} >= DEPTH_L);
    end
  end

  assign mem_err = mem_ready && skip;
`else
  assign skip = 1'b0;
`endif

  assign busy      = (state != ST_IDLE);
  assign mem_ready = (state == ST_DONE);
  assign ram_en    = (state == ST_ACCESS) && !skip;
  assign ram_we    = ram_en && (op == OP_WRITE);

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the Schwap multicycle core.
- Accepts the level-held memRead/memWrite strobes and address/data from the control/datapath side and performs one access per request on a single-port synchronous RAM (1-cycle read latency).
- Inserts programmable wait states, returns read data with a one-cycle ready pulse, and re-arms only after the strobe drops, so held strobes never cause duplicate accesses.

Parameters:
- DW, 16, data word width
- AW, 16, address width
- DEPTH, 1024, number of implemented RAM words (valid addresses 0..DEPTH-1)
- WAIT_CYCLES, 0, extra cycles between request capture and RAM access (0..15)

Ports:
- clk  in  1  single system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- mem_read  in  1  read strobe, level, held by requester
- mem_write  in  1  write strobe, level, held by requester
- addr  in  AW  word address, sampled at capture
- wdata  in  DW  write data, sampled at capture
- rdata  out  DW  read data register, holds last read value
- mem_ready  out  1  one-cycle completion pulse
- busy  out  1  high from capture until the block returns to IDLE
- ram_en  out  1  RAM enable
- ram_we  out  1  RAM write enable
- ram_addr  out  AW  RAM address (latched)
- ram_wdata  out  DW  RAM write data (latched)
- ram_rdata  in  DW  RAM read data, valid the cycle after ram_en

Behaviour:
- Reset (async, any state): state=IDLE; rdata=0, mem_ready=0, busy=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, wait counter=0. An in-flight access is abandoned and a partially issued write is dropped (ram_we falls with reset).
- States: IDLE, WAIT, ACCESS, RESP, DONE, HOLD.
- IDLE -> capture on a rising edge with mem_read|mem_write. Latch addr, wdata and op; write wins if both strobes are high. Next state is WAIT when WAIT_CYCLES>0, else ACCESS.
- WAIT: counter loads WAIT_CYCLES-1 at capture and decrements each cycle; leave at 0 -> ACCESS.
- ACCESS: exactly 1 cycle with ram_en=1, and ram_we=1 for writes. Read -> RESP; write -> DONE.
- RESP: ram_rdata is valid; the edge leaving RESP loads rdata. Next state DONE.
- DONE: mem_ready=1 for exactly 1 cycle. Next state HOLD if either strobe is still high, else IDLE.
- HOLD: wait until mem_read=0 and mem_write=0, then IDLE. No new capture is possible in HOLD.
- busy = state != IDLE.
- Latency, with edge 0 as the capture edge:
  - read: mem_ready high after edge WAIT_CYCLES+2
  - write: mem_ready high after edge WAIT_CYCLES+1
- Strobe changes after capture are ignored. addr/wdata changes after capture do not affect the access.
- rdata is unchanged by writes.
- Back-to-back: the earliest next capture is the first edge in IDLE after the strobes drop.
- WAIT_CYCLES>15 is a configuration error; guard it with an elaboration-time check.

Optional Feature:
- Macro: MEM_RANGE_CHECK_EN.
- Defined:
  - Adds output mem_err (1 bit, reset 0).
  - A captured addr >= DEPTH skips the RAM access: ram_en stays 0 and the FSM goes WAIT/ACCESS-slot -> DONE with identical cycle timing.
  - A read sets rdata=0; a write changes nothing.
  - mem_err pulses together with mem_ready.
- Undefined:
  - No mem_err port.
  - Out-of-range addresses go to the RAM unchanged (wrap per RAM).

Decomposition:
- Package schwap_mem_pkg:
  - FSM state encoding constants
  - default DW/AW
  - op encoding (OP_READ, OP_WRITE)
- Sub-module mem_wait_counter: loadable down-counter with a zero flag, driving WAIT exit; reusable by other Schwap peripherals.

Test Plan:
- WAIT_CYCLES=0, write addr=0x0010 wdata=0xBEEF, strobe held 5 cycles -> ram_en/ram_we high for one cycle only at the edge-1 cycle, mem_ready pulse after edge 1, HOLD until strobe low, no second write.
- Same config, read addr=0x0010 with RAM model returning 0xBEEF -> rdata=0xBEEF and mem_ready after edge 2; busy low one cycle after strobe release.
- WAIT_CYCLES=3, read -> ram_en after edge 3, mem_ready after edge 5; addr changed to 0x0020 during WAIT has no effect (ram_addr stays 0x0010).
- mem_read and mem_write both high with addr=0x0004 wdata=0x1234 -> write performed, rdata unchanged.
- rst_n pulsed low during WAIT of a write -> all outputs 0 immediately, no ram_we ever asserted; after release with the strobe still high, a fresh capture occurs.
- MEM_RANGE_CHECK_EN, DEPTH=1024, read addr=0x0400 -> ram_en never high, rdata=0, mem_err and mem_ready pulse together after edge 2.
